// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction memory fetch port:
//   NOP_INSTR      - instruction written by the post-reset sweep and returned
//                    on faulted fetches (addi x0, x0, 0)
//   state_t        - controller states (INIT sweep, RUN service)
//   fault_t        - response fault code, with FAULT_NONE / FAULT_MISALIGN /
//                    FAULT_RANGE values
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [1:0] fault_t;

    localparam fault_t FAULT_NONE     = 2'b00;
    localparam fault_t FAULT_MISALIGN = 2'b01;
    localparam fault_t FAULT_RANGE    = 2'b10;

endpackage

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram
// Word-indexed byte storage for the instruction memory.
// Ports:
//   clk    - rising-edge clock
//   we     - write strobe
//   be     - byte enables, bit i writes byte i of the addressed word
//   waddr  - write word index
//   wdata  - write data, little-endian (byte 0 in bits 7:0)
//   re     - read strobe; rdata only changes when re is high
//   raddr  - read word index
//   rdata  - registered read data, read-first with respect to a same-cycle
//            write to the same word
// -----------------------------------------------------------------------------
module imem_ram
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    // Byte-masked write and holding read register share one process. Because
    // both use non-blocking updates, a read of a word being written in the
    // same cycle returns the contents from before the write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[waddr][b] <= wdata[8*b +: 8];
                end
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_fetch_port.sv
// -----------------------------------------------------------------------------
// imem_fetch_port
// Synchronous instruction memory with a valid/ready fetch port, a word-wide
// program-load port and a post-reset NOP sweep.
// Parameters:
//   DEPTH_WORDS - storage depth in 32-bit words (power of two, >= 4)
//   ADDR_W      - width of fetch PC and program address
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   req_valid/req_ready - fetch handshake, req_pc is the byte address
//   resp_valid/ready    - response handshake; resp_instr and resp_fault are
//                         held in an output register, 1-cycle latency
//   prog_we/be/addr/data- program-load write port (ignored during the sweep)
//   init_busy           - high while the NOP sweep runs
// Build option:
//   IMEM_FAULT_EN defined   - misaligned / out-of-range fetches are flagged in
//                             resp_fault, out-of-range program writes dropped
//   IMEM_FAULT_EN undefined - addresses are truncated to a word boundary and
//                             wrap modulo the memory size, resp_fault is 00
// -----------------------------------------------------------------------------
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_instr,
    output logic [1:0]        resp_fault,
    input  logic              prog_we,
    input  logic [3:0]        prog_be,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [31:0]       prog_data,
    output logic              init_busy
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] idx;

    fault_t           req_fault;
    logic             prog_drop;
    logic             accept;

    logic             ram_we;
    logic [3:0]       ram_be;
    logic [IDX_W-1:0] ram_waddr;
    logic [31:0]      ram_wdata;
    logic             ram_re;
    logic [31:0]      ram_rdata;

    logic             resp_from_ram;

    // Address checking. With faults enabled the upper address bits above the
    // storage range flag a range fault (and drop program writes); without
    // faults those bits and the byte offset are simply discarded so that
    // addresses wrap onto the storage.
`ifdef IMEM_FAULT_EN
    always_comb begin
        req_fault = FAULT_NONE;
        if (req_pc[1:0] != 2'b00) begin
            req_fault = FAULT_MISALIGN;
        end else if (|req_pc[ADDR_W-1:IDX_W+2]) begin
            req_fault = FAULT_RANGE;
        end
    end

    assign prog_drop = |prog_addr[ADDR_W-1:IDX_W+2];

    logic unused_prog_lsb;
    assign unused_prog_lsb = ^prog_addr[1:0];
`else
    assign req_fault = FAULT_NONE;
    assign prog_drop = 1'b0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_pc[ADDR_W-1:IDX_W+2], req_pc[1:0],
                                prog_addr[ADDR_W-1:IDX_W+2], prog_addr[1:0]};
`endif

    // Controller state register. Reset always returns to the sweep so that
    // storage contents are rebuilt from scratch after every reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    // Sweep counter: advances one word per cycle while in INIT, so the sweep
    // lasts exactly DEPTH_WORDS cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (state == INIT) begin
            idx <= idx + IDX_W'(1);
        end
    end

    // Next-state logic plus the storage write-port mux. During INIT the sweep
    // owns the write port and fetches are blocked; in RUN the program port
    // owns it and fetches are accepted whenever the output register is free
    // or being emptied this cycle.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        init_busy  = 1'b0;
        ram_we     = 1'b0;
        ram_be     = 4'h0;
        ram_waddr  = idx;
        ram_wdata  = NOP_INSTR;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                ram_we    = 1'b1;
                ram_be    = 4'hF;
                if (idx == LAST_IDX) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                req_ready = !resp_valid || resp_ready;
                if (prog_we && !prog_drop) begin
                    ram_we    = 1'b1;
                    ram_be    = prog_be;
                    ram_waddr = prog_addr[IDX_W+1:2];
                    ram_wdata = prog_data;
                end
            end
            default: begin
                next_state = INIT;
            end
        endcase
    end

    assign accept = req_valid && req_ready;

    // Faulted fetches never touch storage; the RAM read register then keeps
    // its old value and the response mux substitutes a NOP instead.
    assign ram_re = accept && (req_fault == FAULT_NONE);

    imem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .be   (ram_be),
        .waddr(ram_waddr),
        .wdata(ram_wdata),
        .re   (ram_re),
        .raddr(req_pc[IDX_W+1:2]),
        .rdata(ram_rdata)
    );

    // Response register. The instruction word itself lives in the RAM read
    // register; this block tracks validity, the fault code and whether the
    // word should come from storage or be forced to NOP. A reset discards any
    // pending response, stalled or not.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid    <= 1'b0;
            resp_fault    <= FAULT_NONE;
            resp_from_ram <= 1'b0;
        end else if (accept) begin
            resp_valid    <= 1'b1;
            resp_fault    <= req_fault;
            resp_from_ram <= (req_fault == FAULT_NONE);
        end else if (resp_ready) begin
            resp_valid    <= 1'b0;
        end
    end

    assign resp_instr = resp_from_ram ? ram_rdata : NOP_INSTR;

endmodule

// File: tb/tb_imem_fetch_port.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_port
// Self-checking bench for imem_fetch_port (DEPTH_WORDS=64, ADDR_W=32).
// A byte-array reference model of the memory and a simple response-slot model
// predict every output. Honours IMEM_FAULT_EN the same way as the design:
// with it defined, faults are predicted; without it, addresses wrap.
// -----------------------------------------------------------------------------
module tb_imem_fetch_port;

    localparam int DEPTH_WORDS = 64;
    localparam int ADDR_W      = 32;
    localparam int BYTES       = 4 * DEPTH_WORDS;
    localparam logic [31:0] NOP = 32'h00000013;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_pc;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_instr;
    logic [1:0]        resp_fault;
    logic              prog_we;
    logic [3:0]        prog_be;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_data;
    logic              init_busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: flat byte array plus the single response slot.
    logic [7:0]  mdl_mem [BYTES];
    bit          mdl_run;
    bit          mdl_valid;
    logic [31:0] mdl_instr;
    logic [1:0]  mdl_fault;

    imem_fetch_port #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_instr(resp_instr),
        .resp_fault(resp_fault),
        .prog_we   (prog_we),
        .prog_be   (prog_be),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counted, and reported with tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Model of a fetch: fault classification and little-endian word assembly.
    task automatic modelFetch(input logic [31:0] pc, output logic [31:0] instr,
                              output logic [1:0] fault);
        int unsigned base;
        fault = 2'b00;
`ifdef IMEM_FAULT_EN
        if (pc[1:0] != 2'b00) fault = 2'b01;
        else if (pc >= BYTES) fault = 2'b10;
`endif
        if (fault != 2'b00) begin
            instr = NOP;
        end else begin
            base  = (pc % BYTES) & ~32'd3;
            instr = {mdl_mem[base+3], mdl_mem[base+2], mdl_mem[base+1], mdl_mem[base]};
        end
    endtask

    // Model of a program write: dropped when out of range with faults on,
    // otherwise wrapped onto the storage.
    task automatic modelWrite(input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] data);
        int unsigned base;
`ifdef IMEM_FAULT_EN
        if (addr >= BYTES) return;
`endif
        base = (addr % BYTES) & ~32'd3;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mdl_mem[base+i] = data[8*i +: 8];
        end
    endtask

    task automatic modelReset();
        for (int w = 0; w < DEPTH_WORDS; w++) begin
            {mdl_mem[4*w+3], mdl_mem[4*w+2], mdl_mem[4*w+1], mdl_mem[4*w]} = NOP;
        end
        mdl_valid = 1'b0;
        mdl_run   = 1'b0;
    endtask

    // One clock cycle of stimulus, entered and left at 1 time unit after a
    // rising edge. Checks req_ready before the edge and the response after it.
    task automatic applyStimulus(input string tag, input logic rv, input logic [31:0] pc,
                                 input logic rr, input logic we, input logic [3:0] be,
                                 input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] ei;
        logic [1:0]  ef;
        logic        exp_ready;
        req_valid  = rv;
        req_pc     = pc;
        resp_ready = rr;
        prog_we    = we;
        prog_be    = be;
        prog_addr  = addr;
        prog_data  = data;
        #1;
        exp_ready = mdl_run && (!mdl_valid || rr);
        checkOutput({tag, ".req_ready"}, {31'b0, req_ready}, {31'b0, exp_ready});
        if (rv && exp_ready) begin
            modelFetch(pc, ei, ef);
            mdl_valid = 1'b1;
            mdl_instr = ei;
            mdl_fault = ef;
        end else if (rr) begin
            mdl_valid = 1'b0;
        end
        if (mdl_run && we) modelWrite(addr, be, data);
        @(posedge clk);
        #1;
        checkOutput({tag, ".resp_valid"}, {31'b0, resp_valid}, {31'b0, mdl_valid});
        if (mdl_valid) begin
            checkOutput({tag, ".resp_instr"}, resp_instr, mdl_instr);
            checkOutput({tag, ".resp_fault"}, {30'b0, resp_fault}, {30'b0, mdl_fault});
        end
    endtask

    // Reset (keeping the current inputs), check reset values, then time the
    // sweep while trying to fetch and write, both of which must be ignored.
    task automatic resetAndSweep(input string tag);
        int busy;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, ".rst_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        checkOutput({tag, ".rst_resp_instr"}, resp_instr, NOP);
        checkOutput({tag, ".rst_resp_fault"}, {30'b0, resp_fault}, 32'd0);
        checkOutput({tag, ".rst_init_busy"}, {31'b0, init_busy}, 32'd1);
        checkOutput({tag, ".rst_req_ready"}, {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        req_valid  = 1'b1;
        req_pc     = 32'h4;
        resp_ready = 1'b1;
        prog_we    = 1'b1;
        prog_be    = 4'hF;
        prog_addr  = 32'h4;
        prog_data  = 32'hDEADBEEF;
        modelReset();
        busy = 0;
        while (init_busy === 1'b1 && busy < 4 * DEPTH_WORDS) begin
            busy++;
            #1;
            checkOutput({tag, ".sweep_req_ready"}, {31'b0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput({tag, ".sweep_len"}, busy, DEPTH_WORDS);
        req_valid = 1'b0;
        prog_we   = 1'b0;
        mdl_run   = 1'b1;
    endtask

    initial begin
        logic [31:0] rpc;
        logic [31:0] raddr;
        int          sel;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_pc     = '0;
        resp_ready = 1'b0;
        prog_we    = 1'b0;
        prog_be    = 4'h0;
        prog_addr  = '0;
        prog_data  = '0;
        modelReset();
        @(posedge clk);
        #1;

        resetAndSweep("por");

        // First fetch right after the sweep: a NOP.
        applyStimulus("fetch0", 1, 32'h0, 1, 0, 4'h0, 0, 0);

        // Full write, partial byte write, then fetch the merged word.
        applyStimulus("prog_full", 0, 0, 1, 1, 4'hF, 32'h4, 32'h00853022);
        applyStimulus("prog_byte", 0, 0, 1, 1, 4'b0001, 32'h4, 32'h000000AA);
        applyStimulus("fetch4", 1, 32'h4, 1, 0, 4'h0, 0, 0);
        applyStimulus("idle0", 0, 0, 1, 0, 4'h0, 0, 0);

        // Backpressure: first response held while the second request waits.
        applyStimulus("bp_a", 1, 32'h0, 0, 0, 4'h0, 0, 0);
        applyStimulus("bp_b1", 1, 32'h4, 0, 0, 4'h0, 0, 0);
        applyStimulus("bp_b2", 1, 32'h4, 0, 0, 4'h0, 0, 0);
        applyStimulus("bp_b3", 1, 32'h4, 0, 0, 4'h0, 0, 0);
        applyStimulus("bp_take", 1, 32'h4, 1, 0, 4'h0, 0, 0);
        applyStimulus("bp_drain", 0, 0, 1, 0, 4'h0, 0, 0);

        // Fault boundaries (wrap behaviour when faults are compiled out).
        applyStimulus("f_mis", 1, 32'h6, 1, 0, 4'h0, 0, 0);
        applyStimulus("f_range", 1, 32'h100, 1, 0, 4'h0, 0, 0);
        applyStimulus("f_both", 1, 32'h102, 1, 0, 4'h0, 0, 0);
        applyStimulus("f_last", 1, 32'hFC, 1, 0, 4'h0, 0, 0);
        applyStimulus("f_idle", 0, 0, 1, 0, 4'h0, 0, 0);

        // Same-cycle write and fetch of word 0x8: old then new.
        applyStimulus("rw_same", 1, 32'h8, 1, 1, 4'hF, 32'h8, 32'h01095024);
        applyStimulus("rw_next", 1, 32'h8, 1, 0, 4'h0, 0, 0);

        // Out-of-range program write: dropped or wrapped onto word 2.
        applyStimulus("oor_wr", 0, 0, 1, 1, 4'hF, 32'h108, 32'hCAFEF00D);
        applyStimulus("oor_rd", 1, 32'h8, 1, 0, 4'h0, 0, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)       rpc = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
            else if (sel == 7) rpc = 32'($urandom_range(0, BYTES - 1));
            else if (sel == 8) rpc = 32'h100 + 32'($urandom_range(0, 255));
            else               rpc = $urandom;
            raddr = 32'($urandom_range(0, 2 * BYTES - 1));
            applyStimulus("rand", 1'($urandom_range(0, 1)), rpc,
                          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          4'($urandom_range(0, 15)), raddr, $urandom);
        end
        applyStimulus("rand_drain", 0, 0, 1, 0, 4'h0, 0, 0);

        // Program word 0x4, stall a response, then reset mid-operation.
        applyStimulus("pre_wr", 0, 0, 1, 1, 4'hF, 32'h4, 32'h12345678);
        applyStimulus("pre_rd", 1, 32'h4, 0, 0, 4'h0, 0, 0);
        applyStimulus("pre_hold", 0, 0, 0, 0, 4'h0, 0, 0);
        resetAndSweep("midrst");
        applyStimulus("post_rd", 1, 32'h4, 1, 0, 4'h0, 0, 0);
        applyStimulus("post_idle", 0, 0, 1, 0, 4'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
